// File: rtl/logic_op_sequencer.sv
// logic_op_sequencer
//   Control and accumulator stage feeding a bank of 8-bit gated logic units
//   (OR/AND/XOR). Commands arrive over a valid/ready handshake. Each one takes
//   three cycles: IDLE (accept), EXEC (one unit enabled, result bus sampled)
//   and WB (accumulator written, done/err raised for the following cycle).
//
// Ports
//   clk, rst    rising-edge clock, synchronous active-high reset
//   cmd_valid   command present
//   cmd_ready   sequencer idle and able to accept a command
//   cmd_op      0 NOP, 1 LOAD, 2 OR, 3 AND, 4 XOR, 5 CLR, 6-7 illegal
//   cmd_data    operand
//   unit_in     registered operand, goes to IN of every logic unit
//   unit_sv     accumulator, goes to SV of every logic unit
//   unit_en     one-hot unit enable, [0] OR, [1] AND, [2] XOR, only in EXEC
//   unit_bus    OR of all logic-unit outputs (disabled units drive 0)
//   acc         accumulator
//   zero        acc == 0
//   done        one-cycle pulse, command retired
//   err         one-cycle pulse together with done, illegal opcode retired
module logic_op_sequencer #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] ACC_RESET = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] unit_in,
  output logic [WIDTH-1:0] unit_sv,
  output logic [2:0]       unit_en,
  input  logic [WIDTH-1:0] unit_bus,
  output logic [WIDTH-1:0] acc,
  output logic             zero,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_OR   = 3'd2,
    OP_AND  = 3'd3,
    OP_XOR  = 3'd4,
    OP_CLR  = 3'd5
  } op_e;

  state_e           state, state_n;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] res_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (cmd_valid) state_n = EXEC;
      EXEC:    state_n = WB;
      WB:      state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output decode: a unit is enabled only while its op is executing
  always_comb begin
    unit_en = '0;
    if (state == EXEC) begin
      case (op_q)
        OP_OR:   unit_en = 3'b001;
        OP_AND:  unit_en = 3'b010;
        OP_XOR:  unit_en = 3'b100;
        default: unit_en = 3'b000;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      data_q <= '0;
      res_q  <= '0;
      acc    <= ACC_RESET;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
          end
        end
        EXEC: begin
          res_q <= unit_bus;
        end
        WB: begin
          case (op_q)
            OP_LOAD:                acc <= data_q;
            OP_OR, OP_AND, OP_XOR:  acc <= res_q;
            OP_CLR:                 acc <= ACC_RESET;
            default:                acc <= acc;
          endcase
          done <= 1'b1;
          err  <= (op_q > 3'd5);
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready = (state == IDLE);
  assign unit_in   = data_q;
  assign unit_sv   = acc;
  assign zero      = (acc == '0);

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Bench for logic_op_sequencer with behavioural OR/AND/XOR units on the bus.
module tb_logic_op_sequencer;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] unit_in;
  logic [WIDTH-1:0] unit_sv;
  logic [2:0]       unit_en;
  logic [WIDTH-1:0] unit_bus;
  logic [WIDTH-1:0] acc;
  logic             zero;
  logic             done;
  logic             err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  logic_op_sequencer #(.WIDTH(WIDTH), .ACC_RESET(8'h00)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .unit_in  (unit_in),
    .unit_sv  (unit_sv),
    .unit_en  (unit_en),
    .unit_bus (unit_bus),
    .acc      (acc),
    .zero     (zero),
    .done     (done),
    .err      (err)
  );

  // Behavioural gated logic units: a disabled unit drives 0
  always_comb begin
    unit_bus = '0;
    if (unit_en[0]) unit_bus = unit_bus | (unit_in | unit_sv);
    if (unit_en[1]) unit_bus = unit_bus | (unit_in & unit_sv);
    if (unit_en[2]) unit_bus = unit_bus | (unit_in ^ unit_sv);
  end

  // Present a command and wait (bounded) until it is accepted.
  task automatic send_cmd(input logic [2:0] op, input logic [7:0] data,
                          output bit accepted);
    accepted = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        accepted  = 1'b1;
        break;
      end
    end
  endtask

  // Send a command and observe the four cycles that follow acceptance.
  task automatic run_cmd(input logic [2:0] op, input logic [7:0] data,
                         output bit accepted, output logic [2:0] en_exec,
                         output logic [7:0] in_exec, output logic [7:0] sv_exec,
                         output logic [2:0] en_other, output int done_lat,
                         output int done_cnt, output logic err_at_done,
                         output int err_cnt, output logic [7:0] acc_at_done,
                         output logic ready_at_done, output logic zero_any);
    en_exec = '0; in_exec = '0; sv_exec = '0; en_other = '0;
    done_lat = 0; done_cnt = 0; err_at_done = 1'b0; err_cnt = 0;
    acc_at_done = '0; ready_at_done = 1'b0; zero_any = 1'b0;
    send_cmd(op, data, accepted);
    if (accepted) begin
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        if (c == 1) begin
          en_exec = unit_en; in_exec = unit_in; sv_exec = unit_sv;
        end else begin
          en_other = en_other | unit_en;
        end
        zero_any = zero_any | zero;
        if (err) err_cnt++;
        if (done) begin
          done_cnt++;
          if (done_lat == 0) begin
            done_lat      = c;
            err_at_done   = err;
            acc_at_done   = acc;
            ready_at_done = cmd_ready;
          end
        end
      end
    end
  endtask

  // Observation variables shared by the scenario tasks (one process only)
  bit         acc_ok;
  logic [2:0] o_en_exec, o_en_other;
  logic [7:0] o_in, o_sv, o_acc;
  int         o_lat, o_dcnt, o_ecnt;
  logic       o_err, o_rdy, o_zero;

  task automatic do_cmd(input logic [2:0] op, input logic [7:0] data);
    run_cmd(op, data, acc_ok, o_en_exec, o_in, o_sv, o_en_other, o_lat,
            o_dcnt, o_err, o_ecnt, o_acc, o_rdy, o_zero);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({acc, zero, cmd_ready, unit_en, done, err} !== {8'h00, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: acc=%h zero=%b ready=%b en=%b done=%b err=%b, want acc=00 zero=1 ready=1 en=000 done=0 err=0",
               acc, zero, cmd_ready, unit_en, done, err);
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_load_or();
    do_cmd(3'd1, 8'h5A);
    n_checks++;
    if (!acc_ok || o_acc !== 8'h5A || o_en_exec !== 3'b000 || o_lat != 3) begin
      n_fail++;
      $display("FAIL load_5a: accepted=%b acc=%h en=%b lat=%0d, want 1 5a 000 3", acc_ok, o_acc, o_en_exec, o_lat);
    end
    do_cmd(3'd2, 8'h0F);
    n_checks++;
    if (o_en_exec !== 3'b001 || o_en_other !== 3'b000) begin
      n_fail++;
      $display("FAIL or_enable: exec=%b other=%b, want 001 000", o_en_exec, o_en_other);
    end
    n_checks++;
    if (o_in !== 8'h0F || o_sv !== 8'h5A) begin
      n_fail++;
      $display("FAIL or_operands: in=%h sv=%h, want 0f 5a", o_in, o_sv);
    end
    n_checks++;
    if (o_acc !== 8'h5F || o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL or_result: acc=%h err=%b, want 5f 0", o_acc, o_err);
    end
    n_checks++;
    if (o_lat != 3 || o_dcnt != 1 || o_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL or_done_timing: lat=%0d count=%0d ready=%b, want 3 1 1", o_lat, o_dcnt, o_rdy);
    end
  endtask

  task automatic test_and_xor();
    do_cmd(3'd3, 8'h3C);
    n_checks++;
    if (o_acc !== 8'h1C || o_en_exec !== 3'b010 || o_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL and_3c: acc=%h en=%b zero_seen=%b, want 1c 010 0", o_acc, o_en_exec, o_zero);
    end
    do_cmd(3'd4, 8'hFF);
    n_checks++;
    if (o_acc !== 8'hE3 || o_en_exec !== 3'b100 || o_zero !== 1'b0 || o_dcnt != 1) begin
      n_fail++;
      $display("FAIL xor_ff: acc=%h en=%b zero_seen=%b dones=%0d, want e3 100 0 1", o_acc, o_en_exec, o_zero, o_dcnt);
    end
  endtask

  task automatic test_back_to_back();
    int t[2];
    int k, not_ready;
    apply_reset();
    t[0] = -1; t[1] = -1; k = 0; not_ready = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_data = 8'h01;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      if (cmd_ready) begin
        t[k] = i;
        k++;
      end else begin
        not_ready++;
      end
      @(posedge clk);
      #1;
      if (k == 1) cmd_data = 8'h80;
      if (k == 2) begin
        cmd_valid = 1'b0;
        break;
      end
    end
    n_checks++;
    if (k != 2 || t[1] - t[0] != 3 || not_ready != 2) begin
      n_fail++;
      $display("FAIL b2b_spacing: accepts=%0d gap=%0d not_ready=%0d, want 2 3 2", k, t[1] - t[0], not_ready);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (acc !== 8'h81 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_result: acc=%h done=%b, want 81 1", acc, done);
    end
  endtask

  task automatic test_illegal_clr();
    do_cmd(3'd6, 8'hAA);
    n_checks++;
    if (o_en_exec !== 3'b000 || o_en_other !== 3'b000 || o_acc !== 8'h81) begin
      n_fail++;
      $display("FAIL illegal_noeffect: en=%b/%b acc=%h, want 000/000 81", o_en_exec, o_en_other, o_acc);
    end
    n_checks++;
    if (o_lat != 3 || o_err !== 1'b1 || o_ecnt != 1 || o_dcnt != 1) begin
      n_fail++;
      $display("FAIL illegal_err: lat=%0d err=%b errs=%0d dones=%0d, want 3 1 1 1", o_lat, o_err, o_ecnt, o_dcnt);
    end
    do_cmd(3'd0, 8'h33);
    n_checks++;
    if (o_acc !== 8'h81 || o_err !== 1'b0 || o_lat != 3) begin
      n_fail++;
      $display("FAIL nop: acc=%h err=%b lat=%0d, want 81 0 3", o_acc, o_err, o_lat);
    end
    do_cmd(3'd5, 8'h77);
    n_checks++;
    if (o_acc !== 8'h00 || zero !== 1'b1 || o_err !== 1'b0 || o_ecnt != 0) begin
      n_fail++;
      $display("FAIL clr: acc=%h zero=%b err=%b errs=%0d, want 00 1 0 0", o_acc, zero, o_err, o_ecnt);
    end
  endtask

  task automatic test_reset_mid_cmd();
    int dones, errs;
    bit ok;
    do_cmd(3'd1, 8'h12);
    send_cmd(3'd4, 8'hFF, ok);
    @(negedge clk);
    n_checks++;
    if (!ok || unit_en !== 3'b100 || acc !== 8'h12) begin
      n_fail++;
      $display("FAIL abort_setup: accepted=%b en=%b acc=%h, want 1 100 12", ok, unit_en, acc);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1 || acc !== 8'h00 || unit_en !== 3'b000 || done !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: ready=%b acc=%h en=%b done=%b err=%b, want 1 00 000 0 0",
               cmd_ready, acc, unit_en, done, err);
    end
    rst = 1'b0;
    dones = 0; errs = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dones++;
      if (err) errs++;
    end
    n_checks++;
    if (dones != 0 || errs != 0 || acc !== 8'h00) begin
      n_fail++;
      $display("FAIL abort_nopulse: dones=%0d errs=%0d acc=%h, want 0 0 00", dones, errs, acc);
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
    test_reset();
    test_load_or();
    test_and_xor();
    test_back_to_back();
    test_illegal_clr();
    test_reset_mid_cmd();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
